// File: rtl/id_ex_stage_reg_pkg.sv
// Shared types for the ID/EX stage register: destination-select encoding and EX control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_stage_reg_pkg;

    // Write-destination select driven by the decoder; 2'b11 is unused and falls back to rd.
    typedef enum logic [1:0] {
        DEST_RD  = 2'b00,
        DEST_RT  = 2'b01,
        DEST_TWO = 2'b10,
        DEST_RSV = 2'b11
    } dest_sel_e;

    // Control bits carried into EX; a bubble is this bundle all-zero.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       pc_to_reg;
        logic       halt;
        logic       wwd;
        logic [3:0] func_code;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
// Latency: combinational.
// Backpressure: produces the hazard term the stage register turns into a stall plus one bubble.
module load_use_detect #(
    parameter int REG_AW = 2
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              id_valid,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              hazard
);

    logic rs_match;
    logic rt_match;

    // Only source fields the instruction actually reads can create a dependency.
    assign rs_match = id_uses_rs && (id_rs == ex_dest);
    assign rt_match = id_uses_rt && (id_rt == ex_dest);
    assign hazard   = ex_valid && ex_mem_read && id_valid && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches decoded control/operands, resolves dest, bubbles on load-use/flush, sticky halt.
// Latency: 1 cycle from ID inputs to ex_* outputs.
// Backpressure: stall (combinational) holds PC and IF/ID for one load-use bubble, and permanently once halted.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int REG_AW    = 2,
    parameter int CNT_W     = 16,
    parameter int LINK_REG  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 id_valid,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_mem_to_reg,
    input  logic                 id_mem_write,
    input  logic                 id_pc_to_reg,
    input  logic                 id_halt,
    input  logic                 id_wwd,
    input  logic [1:0]           id_reg_write_dest,
    input  logic [3:0]           id_func_code,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [REG_AW-1:0]    id_rs,
    input  logic [REG_AW-1:0]    id_rt,
    input  logic [REG_AW-1:0]    id_rd,
    input  logic [WORD_SIZE-1:0] id_rs_data,
    input  logic [WORD_SIZE-1:0] id_rt_data,
    input  logic [WORD_SIZE-1:0] id_imm,
    input  logic [WORD_SIZE-1:0] id_pc,
    input  logic                 flush,
    output logic                 stall,
    output logic                 ex_valid,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_to_reg,
    output logic                 ex_mem_write,
    output logic                 ex_pc_to_reg,
    output logic                 ex_halt,
    output logic                 ex_wwd,
    output logic [3:0]           ex_func_code,
    output logic [REG_AW-1:0]    ex_dest,
    output logic [REG_AW-1:0]    ex_rs,
    output logic [REG_AW-1:0]    ex_rt,
    output logic [WORD_SIZE-1:0] ex_rs_data,
    output logic [WORD_SIZE-1:0] ex_rt_data,
    output logic [WORD_SIZE-1:0] ex_imm,
    output logic [WORD_SIZE-1:0] ex_pc,
    output logic                 halted,
    output logic [CNT_W-1:0]     num_inst
);

    ex_ctrl_t            ctrl_q;
    ex_ctrl_t            ctrl_d;
    logic [REG_AW-1:0]   dest_d;
    logic [REG_AW-1:0]   dest_q;
    logic                hazard;
    logic                issue;
    logic                halted_q;
    logic [CNT_W-1:0]    cnt_q;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid    (ctrl_q.valid),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_dest     (dest_q),
        .id_valid    (id_valid),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (hazard)
    );

    // Flush kills ID outright, so it wins over the hazard and must not hold the front end.
    assign issue = id_valid && !flush && !hazard && !halted_q;
    assign stall = halted_q || (hazard && !flush);

    // Destination resolve; the reserved encoding behaves like rd.
    always_comb begin
        dest_d = id_rd;
        case (dest_sel_e'(id_reg_write_dest))
            DEST_RT:  dest_d = id_rt;
            DEST_TWO: dest_d = REG_AW'(LINK_REG);
            default:  dest_d = id_rd;
        endcase
    end

    // Next control bundle: a real instruction on issue, otherwise an all-zero bubble.
    always_comb begin
        ctrl_d = CTRL_BUBBLE;
        if (issue) begin
            ctrl_d.valid      = 1'b1;
            ctrl_d.reg_write  = id_reg_write;
            ctrl_d.mem_read   = id_mem_read;
            ctrl_d.mem_to_reg = id_mem_to_reg;
            ctrl_d.mem_write  = id_mem_write;
            ctrl_d.pc_to_reg  = id_pc_to_reg;
            ctrl_d.halt       = id_halt;
            ctrl_d.wwd        = id_wwd;
            ctrl_d.func_code  = id_func_code;
        end
    end

    // Control register: loaded every cycle, bubbles included.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= CTRL_BUBBLE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Register fields and operands only move on issue; during bubbles they keep their last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dest_q     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
        end else if (issue) begin
            dest_q     <= dest_d;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc      <= id_pc;
        end
    end

    // Sticky halt and issued-instruction counter; both advance only on a real issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else if (issue) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (id_halt) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_pc_to_reg  = ctrl_q.pc_to_reg;
    assign ex_halt       = ctrl_q.halt;
    assign ex_wwd        = ctrl_q.wwd;
    assign ex_func_code  = ctrl_q.func_code;
    assign ex_dest       = dest_q;
    assign halted        = halted_q;
    assign num_inst      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for the ID/EX stage register: directed scenarios then randomized instruction stream vs a reference model.
// Latency: checks ex_* one edge after ID is presented.
// Backpressure: ID is re-presented whenever the model expects stall.
module tb_id_ex_stage_reg;

    typedef struct {
        logic        valid, rw, mr, m2r, mw, p2r, hlt, wwd;
        logic [1:0]  dsel;
        logic [3:0]  func;
        logic        urs, urt;
        logic [1:0]  rs, rt, rd;
        logic [15:0] rsd, rtd, imm, pc;
    } id_t;

    typedef struct {
        logic        valid, rw, mr, m2r, mw, p2r, hlt, wwd;
        logic [3:0]  func;
        logic [1:0]  dest, rs, rt;
        logic [15:0] rsd, rtd, imm, pc;
    } ex_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    id_t         cur;
    logic        stall;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_mem_write;
    logic        ex_pc_to_reg, ex_halt, ex_wwd, halted;
    logic [3:0]  ex_func_code;
    logic [1:0]  ex_dest, ex_rs, ex_rt;
    logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc, num_inst;

    int   n_cmp = 0;
    int   n_bad = 0;
    ex_t  m;
    logic m_halted;
    logic [15:0] m_cnt;
    logic last_stall;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(cur.valid), .id_reg_write(cur.rw), .id_mem_read(cur.mr),
        .id_mem_to_reg(cur.m2r), .id_mem_write(cur.mw), .id_pc_to_reg(cur.p2r),
        .id_halt(cur.hlt), .id_wwd(cur.wwd), .id_reg_write_dest(cur.dsel),
        .id_func_code(cur.func), .id_uses_rs(cur.urs), .id_uses_rt(cur.urt),
        .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .id_rs_data(cur.rsd), .id_rt_data(cur.rtd), .id_imm(cur.imm), .id_pc(cur.pc),
        .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_pc_to_reg(ex_pc_to_reg), .ex_halt(ex_halt), .ex_wwd(ex_wwd),
        .ex_func_code(ex_func_code), .ex_dest(ex_dest), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .halted(halted), .num_inst(num_inst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic id_t blank();
        id_t x;
        x.valid = 1'b1; x.rw = 0; x.mr = 0; x.m2r = 0; x.mw = 0; x.p2r = 0; x.hlt = 0; x.wwd = 0;
        x.dsel = 2'd0; x.func = 4'($urandom_range(0, 15)); x.urs = 0; x.urt = 0;
        x.rs = 2'($urandom_range(0, 3)); x.rt = 2'($urandom_range(0, 3)); x.rd = 2'($urandom_range(0, 3));
        x.rsd = 16'($urandom); x.rtd = 16'($urandom); x.imm = 16'($urandom); x.pc = 16'($urandom);
        return x;
    endfunction

    function automatic id_t mk_add(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd);
        id_t x = blank();
        x.rw = 1; x.dsel = 2'd0; x.func = 4'd0; x.urs = 1; x.urt = 1; x.rs = rs; x.rt = rt; x.rd = rd;
        return x;
    endfunction

    function automatic id_t mk_adi(input logic [1:0] rs, input logic [1:0] rt);
        id_t x = blank();
        x.rw = 1; x.dsel = 2'd1; x.urs = 1; x.rs = rs; x.rt = rt;
        return x;
    endfunction

    function automatic id_t mk_jal();
        id_t x = blank();
        x.rw = 1; x.p2r = 1; x.dsel = 2'd2; x.rd = 2'd0; x.rt = 2'd1;
        return x;
    endfunction

    function automatic id_t mk_lwd(input logic [1:0] rs, input logic [1:0] rt);
        id_t x = blank();
        x.rw = 1; x.mr = 1; x.m2r = 1; x.dsel = 2'd1; x.urs = 1; x.rs = rs; x.rt = rt;
        return x;
    endfunction

    function automatic id_t mk_hlt();
        id_t x = blank();
        x.hlt = 1;
        return x;
    endfunction

    function automatic id_t mk_rand();
        id_t x = blank();
        x.valid = ($urandom_range(0, 9) != 0);
        {x.rw, x.mr, x.m2r, x.mw, x.p2r, x.wwd} = 6'($urandom);
        x.hlt  = ($urandom_range(0, 39) == 0);
        x.dsel = 2'($urandom_range(0, 3));
        x.urs  = 1'($urandom); x.urt = 1'($urandom);
        return x;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic model_hazard();
        return m.valid && m.mr && cur.valid &&
               ((cur.urs && cur.rs == m.dest) || (cur.urt && cur.rt == m.dest));
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m_halted = 0;
        m_cnt = 0;
    endtask

    task automatic model_edge(input logic haz);
        if (flush || haz || !cur.valid || m_halted) begin
            {m.valid, m.rw, m.mr, m.m2r, m.mw, m.p2r, m.hlt, m.wwd} = '0;
            m.func = 4'd0;
        end else begin
            m.valid = 1; m.rw = cur.rw; m.mr = cur.mr; m.m2r = cur.m2r; m.mw = cur.mw;
            m.p2r = cur.p2r; m.hlt = cur.hlt; m.wwd = cur.wwd; m.func = cur.func;
            m.dest = (cur.dsel == 2'd1) ? cur.rt : (cur.dsel == 2'd2) ? 2'd2 : cur.rd;
            m.rs = cur.rs; m.rt = cur.rt;
            m.rsd = cur.rsd; m.rtd = cur.rtd; m.imm = cur.imm; m.pc = cur.pc;
            m_cnt = m_cnt + 16'd1;
            if (cur.hlt) m_halted = 1;
        end
    endtask

    task automatic check_outputs();
        chk("ex_valid", 64'(ex_valid), 64'(m.valid));
        chk("ex_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_pc_to_reg, ex_halt, ex_wwd}),
            64'({m.rw, m.mr, m.m2r, m.mw, m.p2r, m.hlt, m.wwd}));
        chk("halted", 64'(halted), 64'(m_halted));
        chk("num_inst", 64'(num_inst), 64'(m_cnt));
        if (m.valid) begin
            chk("ex_func", 64'(ex_func_code), 64'(m.func));
            chk("ex_regs", 64'({ex_dest, ex_rs, ex_rt}), 64'({m.dest, m.rs, m.rt}));
            chk("ex_data", {ex_rs_data, ex_rt_data, ex_imm, ex_pc}, {m.rsd, m.rtd, m.imm, m.pc});
        end
    endtask

    // One cycle: check stall before the edge, advance model at the edge, check ex_* after it.
    task automatic step();
        logic haz;
        @(negedge clk);
        haz = model_hazard();
        last_stall = stall;
        chk("stall", 64'(stall), 64'(m_halted || (haz && !flush)));
        @(posedge clk);
        model_edge(haz);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        model_reset();
        check_outputs();
        chk("reset_stall", 64'(stall), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1;
    endtask

    initial begin
        int halt_cycles;
        reset_n = 0;
        flush = 0;
        last_stall = 0;
        cur = mk_add(2'd1, 2'd2, 2'd3);
        model_reset();

        // Reset held across edges with an ADD presented in ID.
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_num_inst", 64'(num_inst), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        reset_n = 1;

        // Destination resolve.
        cur = mk_adi(2'd0, 2'd1); step(); chk("dest_rt_w", 64'(ex_dest), 64'(1));
        cur = mk_jal();           step(); chk("dest_two_w", 64'(ex_dest), 64'(2));
        cur = mk_add(2'd0, 2'd1, 2'd3); step(); chk("dest_rd_w", 64'(ex_dest), 64'(3));
        chk("num_after_3", 64'(num_inst), 64'(3));
        cur = mk_add(2'd0, 2'd1, 2'd2); cur.dsel = 2'd3; step(); chk("dest_rsv", 64'(ex_dest), 64'(2));

        // Load-use: exactly one bubble, ADD re-presented and issued.
        cur = mk_lwd(2'd0, 2'd1); step();
        cur = mk_add(2'd1, 2'd2, 2'd0); step();
        chk("lu_stall", 64'(last_stall), 64'(1));
        chk("lu_bubble_valid", 64'(ex_valid), 64'(0));
        chk("lu_bubble_rw", 64'(ex_reg_write), 64'(0));
        step();
        chk("lu_restall", 64'(last_stall), 64'(0));
        chk("lu_issue", 64'(ex_valid), 64'(1));
        chk("lu_num", 64'(num_inst), 64'(6));

        // No false hazard.
        cur = mk_lwd(2'd0, 2'd1); step();
        cur = mk_add(2'd2, 2'd3, 2'd0); step();
        chk("nofalse_stall", 64'(last_stall), 64'(0));
        chk("nofalse_issue", 64'(ex_valid), 64'(1));

        // Flush beats hazard.
        cur = mk_lwd(2'd0, 2'd1); step();
        cur = mk_add(2'd1, 2'd0, 2'd2); flush = 1; step(); flush = 0;
        chk("flush_stall", 64'(last_stall), 64'(0));
        chk("flush_bubble", 64'(ex_valid), 64'(0));
        chk("flush_num", 64'(num_inst), 64'(9));

        // Flushed HLT never sets halted.
        cur = mk_hlt(); flush = 1; step(); flush = 0;
        chk("flush_hlt", 64'(halted), 64'(0));

        // Halt is sticky until reset.
        cur = mk_hlt(); step();
        chk("hlt_set", 64'(halted), 64'(1));
        chk("hlt_ex", 64'(ex_halt), 64'(1));
        cur = mk_add(2'd0, 2'd1, 2'd2);
        repeat (3) begin
            step();
            chk("hlt_stall", 64'(last_stall), 64'(1));
            chk("hlt_frozen", 64'(num_inst), 64'(10));
        end
        do_reset();
        chk("rst_clears_halt", 64'(halted), 64'(0));
        cur = mk_add(2'd0, 2'd1, 2'd2); step();
        chk("post_rst_issue", 64'(ex_valid), 64'(1));
        chk("post_rst_num", 64'(num_inst), 64'(1));

        // Randomized stream; stalled ID is held, halts are cleared by reset after a few cycles.
        halt_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(last_stall && !m_halted)) cur = mk_rand();
            flush = ($urandom_range(0, 7) == 0);
            step();
            if (m_halted) halt_cycles++;
            if (halt_cycles > 4 || $urandom_range(0, 199) == 0) begin
                flush = 0;
                do_reset();
                halt_cycles = 0;
                last_stall = 0;
            end
        end
        flush = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
